// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the SRAM port controller: FSM state encoding,
// default parameter values and timing constants.
// Ports: none (package).
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

    localparam int PHASES_DEF      = 10;
    localparam int SRCLK_PHASE_DEF = 6;
    localparam int WORD_DLY_DEF    = 2;
    localparam int TIMEOUT_CYC     = 64;
    localparam int CNT_W           = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_INST = 3'd1,
        WAIT_PH   = 3'd2,
        WORD_ON   = 3'd3,
        ACTIVE    = 3'd4,
        WORD_OFF  = 3'd5,
        DONE      = 3'd6
    } state_t;

endpackage

// File: rtl/sram_port_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_port_ctrl_if
// Request/response handshake between a requester and the SRAM port
// controller.
//   req_valid / req_ready : request handshake (accepted when both high)
//   req_we, req_wdata     : write enable and write bit
//   rsp_valid             : one-cycle completion pulse
//   rsp_rdata, rsp_err    : read bit and watchdog-timeout flag
// Modports: master (requester side), slave (controller side).
// ---------------------------------------------------------------------------
interface sram_port_ctrl_if;

    logic req_valid;
    logic req_ready;
    logic req_we;
    logic req_wdata;
    logic rsp_valid;
    logic rsp_rdata;
    logic rsp_err;

    modport master (
        output req_valid, req_we, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/sram_port_ctrl_rise_det.sv
// ---------------------------------------------------------------------------
// rise_det
// Rising-edge detector built from a single previous-value flop.
//   clk   : system clock
//   reset : asynchronous active-high reset (clears the previous-value flop)
//   d     : level input to watch
//   rise  : high for the cycle in which d is high and was low on the
//           previous clock edge; the FSM acts on it at the following edge
// ---------------------------------------------------------------------------
module rise_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/sram_port_ctrl.sv
// ---------------------------------------------------------------------------
// sram_port_ctrl
// Sequences one single-bit SRAM access per request, aligned to the Bennett
// clocking scheme: waits for an instruction boundary, opens the access window
// on clkp[SRCLK_PHASE], raises the word lines WORD_DLY cycles later, closes
// on the next Mclk rise and drops the word lines WORD_DLY cycles after that.
//
// Optional feature: define SRAM_CTRL_TIMEOUT_EN to add a watchdog that
// aborts an access stuck in WAIT_INST, WAIT_PH or ACTIVE for TIMEOUT_CYC
// cycles and reports it through rsp_err. Without it rsp_err is tied low and
// the controller waits indefinitely.
//
// Ports:
//   clk, reset           : system clock, asynchronous active-high reset
//   clkp[PHASES]         : Bennett phase bus
//   Mclk, instFlag       : Bennett master phase, instruction boundary marker
//   bus (slave)          : request/response handshake
//   PEn, PEnnot          : port enable and complement
//   srclkpos, srclkneg   : SRAM clock pair
//   wordA, wordB         : word lines
//   bitA_out, bitA_oe    : bitA drive value and enable
//   bitnotB_in           : sensed bitnotB
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | ready for a request
// WAIT_INST | request latched, waiting for an instFlag rise
// WAIT_PH   | port enabled, waiting for the clkp[SRCLK_PHASE] rise
// WORD_ON   | SRAM clock low, counting down to word-line assertion
// ACTIVE    | word lines high, waiting for an Mclk rise
// WORD_OFF  | SRAM clock high again, counting down to word-line release
// DONE      | completion pulse
// ---------------------------------------------------------------------------
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int PHASES      = PHASES_DEF,
    parameter int SRCLK_PHASE = SRCLK_PHASE_DEF,
    parameter int WORD_DLY    = WORD_DLY_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PHASES-1:0] clkp,
    input  logic              Mclk,
    input  logic              instFlag,
    sram_port_ctrl_if.slave   bus,
    output logic              PEn,
    output logic              PEnnot,
    output logic              srclkpos,
    output logic              srclkneg,
    output logic              wordA,
    output logic              wordB,
    output logic              bitA_out,
    output logic              bitA_oe,
    input  logic              bitnotB_in
);

    state_t           state_q;
    state_t           state_d;
    logic             mclk_rise;
    logic             inst_rise;
    logic             ph_rise;
    logic             we_q;
    logic             wdata_q;
    logic             rdata_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_zero;
    logic             accept;
    logic             load_on;
    logic             load_off;
    logic             timeout;
    logic             pen_win;
    logic             unused_clkp;

    // Only one phase bit matters; the rest of the bus is intentionally ignored.
    assign unused_clkp = ^clkp;

    rise_det u_mclk_det (.clk(clk), .reset(reset), .d(Mclk),              .rise(mclk_rise));
    rise_det u_inst_det (.clk(clk), .reset(reset), .d(instFlag),          .rise(inst_rise));
    rise_det u_ph_det   (.clk(clk), .reset(reset), .d(clkp[SRCLK_PHASE]), .rise(ph_rise));

    assign accept   = (state_q == IDLE) && bus.req_valid;
    assign cnt_zero = (cnt_q == '0);
    assign load_on  = (state_q == WAIT_PH) && ph_rise;
    assign load_off = (state_q == ACTIVE) && mclk_rise;

`ifdef SRAM_CTRL_TIMEOUT_EN
    logic [7:0] wd_q;
    logic       err_q;
    logic       watched;

    assign watched = (state_q == WAIT_INST) || (state_q == WAIT_PH) || (state_q == ACTIVE);
    // wd_q holds (cycles already spent in the state - 1), so this fires on
    // the edge that completes the TIMEOUT_CYC-th cycle.
    assign timeout = watched && (wd_q == 8'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                wd_q <= '0;
            end else if (watched && (wd_q != 8'hFF)) begin
                wd_q <= wd_q + 8'd1;
            end
            if (accept) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.rsp_err = err_q && (state_q == DONE);
`else
    assign timeout     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Own-event transitions take priority over the watchdog.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (bus.req_valid) state_d = WAIT_INST;
            WAIT_INST: if (inst_rise)     state_d = WAIT_PH;
                       else if (timeout)  state_d = DONE;
            WAIT_PH:   if (ph_rise)       state_d = WORD_ON;
                       else if (timeout)  state_d = DONE;
            WORD_ON:   if (cnt_zero)      state_d = ACTIVE;
            ACTIVE:    if (mclk_rise)     state_d = WORD_OFF;
                       else if (timeout)  state_d = DONE;
            WORD_OFF:  if (cnt_zero)      state_d = DONE;
            DONE:                         state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // Outputs decode straight from the state register so that an async
    // reset (or a watchdog jump to DONE) returns every pin to its safe level.
    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        srclkpos      = 1'b1;
        wordA         = 1'b0;
        pen_win       = 1'b0;
        unique case (state_q)
            IDLE:     bus.req_ready = 1'b1;
            WAIT_PH:  pen_win = 1'b1;
            WORD_ON:  begin pen_win = 1'b1; srclkpos = 1'b0; end
            ACTIVE:   begin pen_win = 1'b1; srclkpos = 1'b0; wordA = 1'b1; end
            WORD_OFF: begin pen_win = 1'b1; wordA = 1'b1; end
            DONE:     bus.rsp_valid = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            wdata_q <= 1'b0;
            rdata_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                wdata_q <= bus.req_wdata;
            end
            if (load_on || load_off) begin
                cnt_q <= CNT_W'(WORD_DLY - 1);
            end else if (((state_q == WORD_ON) || (state_q == WORD_OFF)) && !cnt_zero) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (load_off && !we_q) begin
                rdata_q <= ~bitnotB_in;
            end
        end
    end

    assign srclkneg      = ~srclkpos;
    assign wordB         = wordA;
    assign PEn           = pen_win & we_q;
    assign PEnnot        = ~PEn;
    assign bitA_oe       = PEn;
    assign bitA_out      = PEn & wdata_q;
    assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_port_ctrl.sv
module tb_sram_port_ctrl;
    import sram_ctrl_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [PHASES_DEF-1:0] clkp;
    logic                  Mclk;
    logic                  instFlag;
    logic                  bitnotB_in;
    logic                  PEn, PEnnot, srclkpos, srclkneg;
    logic                  wordA, wordB, bitA_out, bitA_oe;

    int n_cmp = 0;
    int n_bad = 0;

    sram_port_ctrl_if bus ();

    sram_port_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .clkp       (clkp),
        .Mclk       (Mclk),
        .instFlag   (instFlag),
        .bus        (bus.slave),
        .PEn        (PEn),
        .PEnnot     (PEnnot),
        .srclkpos   (srclkpos),
        .srclkneg   (srclkneg),
        .wordA      (wordA),
        .wordB      (wordB),
        .bitA_out   (bitA_out),
        .bitA_oe    (bitA_oe),
        .bitnotB_in (bitnotB_in)
    );

    always #5 clk = ~clk;

    // inputs: rst rv we wd inst ph mclk nb | expected: ready valid rdata pen spos word bout
    typedef struct packed {
        logic rst, rv, we, wd, inst, ph, mclk, nb;
        logic ready, valid, rdata, pen, spos, word, bout;
    } vec_t;

    localparam int NV = 42;
    vec_t tbl [0:NV-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ph(input logic v);
        clkp                  = '0;
        clkp[0]               = ~v;
        clkp[SRCLK_PHASE_DEF] = v;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] obs();
        return {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
                PEn, PEnnot, bitA_oe, srclkpos, srclkneg, wordA, wordB, bitA_out};
    endfunction

    function automatic logic [11:0] exp12(input vec_t v);
        return {v.ready, v.valid, v.rdata, 1'b0, v.pen, ~v.pen, v.pen,
                v.spos, ~v.spos, v.word, v.word, v.bout};
    endfunction

    task automatic apply(input vec_t v);
        reset         = v.rst;
        bus.req_valid = v.rv;
        bus.req_we    = v.we;
        bus.req_wdata = v.wd;
        instFlag      = v.inst;
        set_ph(v.ph);
        Mclk          = v.mclk;
        bitnotB_in    = v.nb;
    endtask

    // From IDLE: issue one request and step it into ACTIVE.
    task automatic go_active(input string name, input logic we, input logic wd, input logic nb);
        int n;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_wdata = wd;
        bitnotB_in    = nb;
        instFlag      = 1'b0;
        set_ph(1'b0);
        Mclk          = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        instFlag      = 1'b1;
        tick();
        set_ph(1'b1);
        n = 0;
        while (!(wordA && !srclkpos) && n < 8) begin
            tick();
            n++;
        end
        chk({name, "_reach_active"}, {wordA, srclkpos}, 2'b10);
    endtask

    // Drive Mclk once the access window is open and wait for the pulse.
    task automatic run_to_done(input string name, output int n_ready);
        int n;
        n_ready = 0;
        n = 0;
        while (!bus.rsp_valid && n < 16) begin
            if (wordA && !srclkpos) Mclk = 1'b1;
            tick();
            n++;
            if (!bus.rsp_valid && bus.req_ready) n_ready++;
        end
        chk({name, "_done"}, bus.rsp_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1, "time limit");
    end

    initial begin
        int nr;
        int nv;
        int n;

        tbl = '{
            {8'b10000001, 7'b1000100},  // reset -> IDLE
            {8'b01110001, 7'b0000100},  // write 1 accepted
            {8'b00000111, 7'b0000100},  // ph/Mclk rise ignored in WAIT_INST
            {8'b00001001, 7'b0001101},  // inst rise -> WAIT_PH
            {8'b00001001, 7'b0001101},
            {8'b00001101, 7'b0001001},  // phase-6 rise -> WORD_ON
            {8'b00001101, 7'b0001001},
            {8'b00001101, 7'b0001011},  // word lines up
            {8'b00000001, 7'b0001011},
            {8'b00000011, 7'b0001111},  // Mclk rise -> WORD_OFF
            {8'b00000011, 7'b0001111},
            {8'b00000011, 7'b0100100},  // DONE
            {8'b00000001, 7'b1000100},
            {8'b01010001, 7'b0000100},  // read, bitnotB=0
            {8'b00001000, 7'b0000100},
            {8'b00001100, 7'b0000000},
            {8'b00001100, 7'b0000000},
            {8'b00001100, 7'b0000010},
            {8'b00000010, 7'b0010110},  // capture rdata=1
            {8'b00000010, 7'b0010110},
            {8'b00000010, 7'b0110100},
            {8'b00000001, 7'b1010100},
            {8'b01100001, 7'b0010100},  // write 0, simultaneous edges
            {8'b00001001, 7'b0011100},
            {8'b00001111, 7'b0011000},  // ph and Mclk rise together
            {8'b00001111, 7'b0011000},
            {8'b00001111, 7'b0011010},
            {8'b00001111, 7'b0011010},  // held Mclk is not a new rise
            {8'b00000001, 7'b0011010},
            {8'b00000011, 7'b0011110},
            {8'b00000011, 7'b0011110},
            {8'b00000011, 7'b0110100},  // write keeps old rdata
            {8'b00000001, 7'b1010100},
            {8'b01000001, 7'b0010100},  // read, bitnotB=1
            {8'b00001001, 7'b0010100},
            {8'b00001101, 7'b0010000},
            {8'b00001101, 7'b0010000},
            {8'b00001101, 7'b0010010},
            {8'b00000011, 7'b0000110},  // capture rdata=0
            {8'b00000011, 7'b0000110},
            {8'b00000011, 7'b0100100},
            {8'b00000001, 7'b1000100}
        };

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_wdata = 1'b0;
        instFlag      = 1'b0;
        Mclk          = 1'b0;
        bitnotB_in    = 1'b1;
        set_ph(1'b0);
        tick();

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i]);
            tick();
            chk($sformatf("vec%0d", i), obs(), exp12(tbl[i]));
        end

        // Back-to-back: req_valid held through the first operation.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_wdata = 1'b1;
        instFlag      = 1'b0;
        set_ph(1'b0);
        Mclk          = 1'b0;
        tick();
        chk("b2b_first_accept", {bus.req_ready, PEn, srclkpos}, 3'b001);
        instFlag = 1'b1;
        tick();
        chk("b2b_first_wait_ph", {bus.req_ready, PEn}, 2'b01);
        set_ph(1'b1);
        run_to_done("b2b_first", nr);
        chk("b2b_ready_low_until_done", nr, 0);
        chk("b2b_ready_low_in_done", bus.req_ready, 1'b0);
        instFlag = 1'b0;
        set_ph(1'b0);
        Mclk     = 1'b0;
        tick();
        chk("b2b_idle_ready", {bus.req_ready, bus.rsp_valid}, 2'b10);
        tick();
        chk("b2b_second_accept", {bus.req_ready, PEn, srclkpos}, 3'b001);
        set_ph(1'b1);
        Mclk = 1'b1;
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (PEn || !srclkpos || bus.rsp_valid) nv++;
        end
        chk("b2b_second_waits_inst", nv, 0);
        bus.req_valid = 1'b0;
        set_ph(1'b0);
        Mclk     = 1'b0;
        instFlag = 1'b1;
        tick();
        chk("b2b_second_start", {bus.req_ready, PEn, bitA_out}, 3'b011);
        set_ph(1'b1);
        run_to_done("b2b_second", nr);
        Mclk = 1'b0;
        tick();

        // Read with bitnotB=0 leaves rdata=1 for the reset test.
        go_active("rd", 1'b0, 1'b0, 1'b0);
        chk("rd_pen_low", {PEn, bitA_oe}, 2'b00);
        run_to_done("rd", nr);
        chk("rd_rdata", bus.rsp_rdata, 1'b1);
        Mclk = 1'b0;
        tick();

        // Asynchronous reset in the middle of ACTIVE.
        go_active("rst", 1'b1, 1'b1, 1'b1);
        chk("rdata_hold_active", bus.rsp_rdata, 1'b1);
        reset = 1'b1;
        #2;
        chk("reset_async_values", obs(), 12'b1000_0101_0000);
        tick();
        tick();
        reset = 1'b0;
        Mclk  = 1'b1;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.rsp_valid) nv++;
        end
        chk("reset_no_valid", nv, 0);
        chk("reset_back_idle", {bus.req_ready, srclkpos, wordA}, 3'b110);
        Mclk = 1'b0;
        tick();

        go_active("to", 1'b1, 1'b1, 1'b1);
`ifdef SRAM_CTRL_TIMEOUT_EN
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            tick();
            n++;
        end
        chk("timeout_cycles", n, TIMEOUT_CYC);
        chk("timeout_outputs", {bus.rsp_valid, bus.rsp_err, srclkpos, srclkneg,
                                wordA, wordB, PEn, bitA_oe}, 8'b11100000);
        tick();
        chk("timeout_err_clears", {bus.req_ready, bus.rsp_valid, bus.rsp_err}, 3'b100);
`else
        nv = 0;
        n  = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.rsp_valid || bus.rsp_err) nv++;
            n++;
        end
        chk("no_timeout_waits", {nv[7:0], wordA, srclkpos}, {8'd0, 2'b10});
        run_to_done("no_timeout", nr);
        chk("no_timeout_err", bus.rsp_err, 1'b0);
        Mclk = 1'b0;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_port_ctrl.md
SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

Interface
REQ-001 SHALL have parameter PHASES, default 10: width of the Bennett phase bus.
REQ-002 SHALL have parameter SRCLK_PHASE, default 6: index of the clkp bit that opens the access window.
REQ-003 SHALL have parameter WORD_DLY, default 2: clk cycles from an SRAM-clock edge to the matching word-line edge.
REQ-004 SHALL have ports, one clock, asynchronous active-high reset:
- clk  in  1  system clock; also drives bennett_clock.
- reset  in  1  asynchronous, active-high.
- clkp  in  PHASES  Bennett phase bus.
- Mclk  in  1  Bennett master phase.
- instFlag  in  1  instruction boundary marker.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_we  in  1  1 = write, 0 = read.
- req_wdata  in  1  write bit.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  1  read bit.
- rsp_err  out  1  timeout flag.
- PEn, PEnnot  out  1 each  port enable and its complement.
- srclkpos, srclkneg  out  1 each  SRAM clock pair.
- wordA, wordB  out  1 each  word lines.
- bitA_out, bitA_oe  out  1 each  bitA drive value and its enable.
- bitnotB_in  in  1  sensed bitnotB.

Function
REQ-005 SHALL detect rising edges of Mclk, instFlag and clkp[SRCLK_PHASE] with one registered previous-value flop each; a detected edge is visible one cycle after the input rises.
REQ-006 SHALL implement states IDLE, WAIT_INST, WAIT_PH, WORD_ON, ACTIVE, WORD_OFF and DONE.
REQ-007 SHALL drive req_ready=1 only in IDLE; on req_valid&&req_ready it SHALL latch req_we and req_wdata and go to WAIT_INST.
REQ-008 WAIT_INST SHALL go to WAIT_PH on an instFlag rise.
REQ-009 WAIT_PH SHALL, on a clkp[SRCLK_PHASE] rise, set srclkpos=0 and srclkneg=1, load the counter with WORD_DLY-1, and go to WORD_ON.
REQ-010 WORD_ON SHALL count down, then assert wordA=wordB=1 and go to ACTIVE.
REQ-011 ACTIVE SHALL, on an Mclk rise:
- set srclkpos=1 and srclkneg=0;
- for a read, capture rsp_rdata = ~bitnotB_in;
- load the counter with WORD_DLY-1 and go to WORD_OFF.
REQ-012 WORD_OFF SHALL count down, then drop wordA=wordB=0 and go to DONE.
REQ-013 DONE SHALL pulse rsp_valid for exactly one cycle and return to IDLE.
REQ-014 PEn SHALL equal the latched we from WAIT_PH through WORD_OFF and be 0 otherwise; PEnnot SHALL always equal ~PEn.
REQ-015 bitA_oe SHALL equal PEn; bitA_out SHALL equal the latched wdata while PEn=1.
REQ-016 Each state SHALL react only to its own event; events arriving in other states SHALL be ignored.
REQ-017 srclkpos and srclkneg SHALL never be equal.
REQ-018 Word lines SHALL never be high while srclkpos=1, except during WORD_OFF.
REQ-019 rsp_rdata SHALL hold its value until the next read capture.

Reset
REQ-020 While reset is high, the block SHALL immediately force:
- state=IDLE;
- srclkpos=1, srclkneg=0;
- wordA=wordB=0;
- PEn=0, PEnnot=1, bitA_oe=0;
- rsp_valid=0, rsp_rdata=0, rsp_err=0;
- edge flops=0 and counters=0.
REQ-021 A reset during any state SHALL abort the operation with no rsp_valid pulse.

Configuration
REQ-022 With SRAM_CTRL_TIMEOUT_EN defined, an 8-bit watchdog SHALL:
- clear on entry to WAIT_INST, WAIT_PH or ACTIVE;
- after 64 cycles in any of those states, force srclkpos=1, srclkneg=0, wordA=wordB=0 and PEn=0;
- then go to DONE with rsp_err=1 for that pulse.
REQ-023 Without SRAM_CTRL_TIMEOUT_EN, rsp_err SHALL be tied 0, no watchdog logic SHALL exist, and the block SHALL wait indefinitely.

Structure
REQ-024 Package sram_ctrl_pkg SHALL hold:
- the state enum;
- the default values of PHASES, SRCLK_PHASE and WORD_DLY;
- the timeout constant 64.
REQ-025 Edge detection SHALL be a sub-module rise_det (clk, reset, d, rise), instantiated three times.

Verification
REQ-026 Reset: assert reset mid-ACTIVE -> outputs take the REQ-020 values immediately and no rsp_valid follows.
REQ-027 Write 1: req_we=1, req_wdata=1 ->
- PEn=1 and bitA_oe=1 from the phase-6 edge;
- word lines rise 2 cycles after srclkpos falls and fall 2 cycles after srclkpos rises;
- rsp_valid=1 for exactly one cycle.
REQ-028 Read: bench holds bitnotB_in=0 -> PEn=0 throughout and rsp_rdata=1 at the rsp_valid pulse.
REQ-029 Back-to-back: second req_valid held high during the first operation -> req_ready=0 until DONE, and the second operation starts on the next instFlag rise.
REQ-030 Simultaneous edges: force Mclk and clkp[6] to rise in the same cycle while in WAIT_PH -> only the phase-6 edge acts.
REQ-031 Timeout (SRAM_CTRL_TIMEOUT_EN defined): hold Mclk low in ACTIVE -> after 64 cycles, word lines=0, srclkpos=1, and rsp_valid=1 with rsp_err=1.
